bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Round-robin arbiter for the shared burst bus. Takes requestTransaction from up to NUM_MASTERS
//  bus masters (DMA engines, CPU bridge) and drives their transactionGranted inputs.
//  Tracks begin/end of each granted transaction on the shared bus. Releases the bus
//  when the transaction ends or the grant goes unused, so one master cannot lock the bus.
// PARAMETERS
//  NUM_MASTERS    4    number of requesters (2..8)
//  GRANT_TIMEOUT  16   max cycles a grant may sit before beginTransaction arrives (>=2)
//  WATCHDOG_CYCLES 1023 max cycles from beginTransaction to endTransaction (WATCHDOG_EN only)
// PORTS
//  clock               in   1            system clock, all logic on rising edge
//  reset               in   1            asynchronous, active-low reset
//  request             in   NUM_MASTERS  per-master requestTransaction, level, held until granted
//  grant               out  NUM_MASTERS  per-master transactionGranted, one-hot or zero, registered
//  beginTransactionIn  in   1            shared-bus begin strobe (OR of all masters)
//  endTransactionIn    in   1            shared-bus end strobe (from slave or master)
//  busErrorOut         out  1            watchdog-forced bus error, 1-cycle pulse
//  endTransactionOut   out  1            watchdog-forced end, 1-cycle pulse with busErrorOut
//  activeMaster        out  3            index of current/last granted master (debug/status)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, grant=0, busErrorOut=0, endTransactionOut=0,
//   activeMaster=0, priority pointer=0 (master 0 highest), timers=0.
//  FSM states: IDLE, GRANT, BUSY, RELEASE.
//  IDLE: if |request, pick the first requester at or after the pointer (wrapping at NUM_MASTERS-1->0).
//   Next cycle: grant[winner]=1, activeMaster=winner, state=GRANT. Request-to-grant latency = 1 cycle.
//  GRANT: grant held. beginTransactionIn=1 -> BUSY, grant kept high. Timer counts cycles in GRANT.
//   If the timer reaches GRANT_TIMEOUT, or request[winner] drops, -> RELEASE.
//  BUSY: grant held. endTransactionIn=1 -> RELEASE. Simultaneous begin+end in GRANT is treated
//   as a complete transaction (-> RELEASE).
//  RELEASE: grant=0 for exactly one dead cycle (bus turnaround). Pointer <= winner+1 (wrapped).
//   -> IDLE. A released master may win again only after all other pending requesters are served.
//  Grant never moves between masters without passing through RELEASE; grant is never multi-hot.
//  beginTransactionIn outside GRANT/BUSY is ignored. endTransactionIn outside BUSY is ignored.
//  A request that appears in the same cycle as the RELEASE->IDLE transition takes part in the
//   next arbitration normally.
//  Timer widths: $clog2(GRANT_TIMEOUT+1), $clog2(WATCHDOG_CYCLES+1). Timers saturate, never wrap.
// CONFIGURATION
//  WATCHDOG_EN defined: in BUSY, count cycles since begin. At WATCHDOG_CYCLES with no endTransactionIn,
//   pulse busErrorOut=1 and endTransactionOut=1 for one cycle, then -> RELEASE.
//   endTransactionIn in the same cycle as expiry takes priority: no error pulse.
//  WATCHDOG_EN undefined: BUSY waits indefinitely. busErrorOut and endTransactionOut tied to 0.
// STRUCTURE
//  Shared package bus_pkg: arbiter state enum (IDLE/GRANT/BUSY/RELEASE, 2 bits) and the
//   bus-timing constants, also used by DMA and slave models.
//  One sub-module rr_priority_pick: combinational round-robin picker
//   (inputs request and pointer, outputs valid and index).
//  Top level holds the FSM, pointer, timers and output registers.
// TESTING
//  Single master: req[2]=1 at cycle 0 -> grant=4'b0100 at cycle 1. Begin at 3, end at 7 -> grant=0 at 8.
//  All four requesting continuously, each transaction 3 cycles -> grant order 0,1,2,3,0,
//   with exactly one zero-grant cycle between each grant.
//  Grant timeout: req[1] held, no begin -> grant[1] drops after 16 cycles. Pointer moves on,
//   so req[3] is granted next.
//  Watchdog (WATCHDOG_EN): begin, then no end for 1023 cycles -> busErrorOut=endTransactionOut=1
//   for 1 cycle, grant=0 the cycle after.
//  Watchdog race: endTransactionIn in the expiry cycle -> no busErrorOut pulse, normal release.
//  Reset mid-BUSY: reset=0 asynchronously -> grant=0 immediately. After release, req[3] wins
//   over req[0]? No: the pointer resets to 0, so master 0 wins first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, bus-timing defaults and an
// index helper. Also used by the DMA and slave models.
package bus_pkg;

    localparam int unsigned BUS_NUM_MASTERS     = 4;
    localparam int unsigned BUS_GRANT_TIMEOUT   = 16;
    localparam int unsigned BUS_WATCHDOG_CYCLES = 1023;
    localparam int unsigned BUS_IDX_W           = 3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    // Next master index after idx, wrapping from n-1 back to 0.
    function automatic logic [BUS_IDX_W-1:0] wrap_inc(input logic [BUS_IDX_W-1:0] idx,
                                                      input int unsigned n);
        logic [BUS_IDX_W-1:0] nxt;
        nxt = idx + BUS_IDX_W'(1);
        if (32'(idx) + 32'd1 >= n) nxt = '0;
        return nxt;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request bit at or after pointer,
// wrapping from N-1 to 0.
// Ports:
//   request  in   N          pending requests
//   pointer  in   BUS_IDX_W  highest-priority index (must be < N)
//   valid    out  1          at least one request pending
//   index    out  BUS_IDX_W  winning master index
module rr_priority_pick
    import bus_pkg::*;
#(
    parameter int unsigned N = BUS_NUM_MASTERS
) (
    input  logic [N-1:0]           request,
    input  logic [BUS_IDX_W-1:0]   pointer,
    output logic                   valid,
    output logic [BUS_IDX_W-1:0]   index
);

    logic [N-1:0] rotated;
    int unsigned  slot;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        rotated = N'({request, request} >> pointer);
        valid   = 1'b0;
        index   = '0;
        slot    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                slot  = 32'(pointer) + i;
                if (slot >= N) slot = slot - N;
                index = BUS_IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared burst bus. Grants one master at a time,
// follows the begin/end strobes of the granted transaction and frees the bus
// on end, on an unused grant (timeout or request withdrawn), or on watchdog.
// Optional feature macro: WATCHDOG_EN (BUSY-phase watchdog with error pulse).
// Ports:
//   clock               in   1            rising-edge clock
//   reset               in   1            async active-low reset
//   request             in   NUM_MASTERS  per-master request, level
//   grant               out  NUM_MASTERS  one-hot or zero, registered
//   beginTransactionIn  in   1            shared-bus begin strobe
//   endTransactionIn    in   1            shared-bus end strobe
//   busErrorOut         out  1            watchdog error pulse
//   endTransactionOut   out  1            watchdog-forced end pulse
//   activeMaster        out  3            current/last granted master
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = BUS_NUM_MASTERS,
    parameter int unsigned GRANT_TIMEOUT   = BUS_GRANT_TIMEOUT,
    parameter int unsigned WATCHDOG_CYCLES = BUS_WATCHDOG_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] grant,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    output logic                   busErrorOut,
    output logic                   endTransactionOut,
    output logic [2:0]             activeMaster
);

    localparam int unsigned GT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

    arb_state_e              state, state_next;
    logic [NUM_MASTERS-1:0]  grant_next;
    logic [BUS_IDX_W-1:0]    active_next;
    logic [BUS_IDX_W-1:0]    pointer, pointer_next;
    logic [GT_W-1:0]         grant_timer, grant_timer_next;
    logic [WD_W-1:0]         busy_timer, busy_timer_next;
    logic                    pick_valid;
    logic [BUS_IDX_W-1:0]    pick_index;
    logic                    owner_request;
    logic                    drop_grant;
`ifdef WATCHDOG_EN
    logic                    bus_error, bus_error_next;
`endif

    rr_priority_pick #(.N(NUM_MASTERS)) u_pick (
        .request (request),
        .pointer (pointer),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    // Grant is one-hot on the owner, so this is request[owner] while granted.
    assign owner_request = |(request & grant);

    // Next-state and registered-output logic.
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        active_next      = activeMaster;
        pointer_next     = pointer;
        grant_timer_next = grant_timer;
        busy_timer_next  = busy_timer;
        drop_grant       = 1'b0;
`ifdef WATCHDOG_EN
        bus_error_next   = 1'b0;
`endif
        case (state)
            // The RELEASE dead cycle also arbitrates, so back-to-back grants
            // are separated by exactly one zero-grant cycle.
            ARB_IDLE, ARB_RELEASE: begin
                if (pick_valid) begin
                    state_next       = ARB_GRANT;
                    grant_next       = NUM_MASTERS'(1) << pick_index;
                    active_next      = pick_index;
                    grant_timer_next = '0;
                end else begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (grant_timer != GT_W'(GRANT_TIMEOUT)) begin
                    grant_timer_next = grant_timer + GT_W'(1);
                end
                if (beginTransactionIn && endTransactionIn) begin
                    drop_grant = 1'b1;
                end else if (beginTransactionIn) begin
                    state_next      = ARB_BUSY;
                    busy_timer_next = '0;
                end else if (!owner_request || grant_timer == GT_W'(GRANT_TIMEOUT - 1)) begin
                    drop_grant = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (busy_timer != WD_W'(WATCHDOG_CYCLES)) begin
                    busy_timer_next = busy_timer + WD_W'(1);
                end
                if (endTransactionIn) begin
                    drop_grant = 1'b1;
`ifdef WATCHDOG_EN
                end else if (bus_error) begin
                    drop_grant = 1'b1;
                end else if (busy_timer == WD_W'(WATCHDOG_CYCLES - 1)) begin
                    bus_error_next = 1'b1;
`endif
                end
            end
            default: state_next = ARB_IDLE;
        endcase

        // Leaving the owner: dead cycle, and the owner drops to lowest priority.
        if (drop_grant) begin
            state_next   = ARB_RELEASE;
            grant_next   = '0;
            pointer_next = wrap_inc(activeMaster, NUM_MASTERS);
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            grant        <= '0;
            activeMaster <= '0;
            pointer      <= '0;
            grant_timer  <= '0;
            busy_timer   <= '0;
`ifdef WATCHDOG_EN
            bus_error    <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            activeMaster <= active_next;
            pointer      <= pointer_next;
            grant_timer  <= grant_timer_next;
            busy_timer   <= busy_timer_next;
`ifdef WATCHDOG_EN
            bus_error    <= bus_error_next;
`endif
        end
    end

`ifdef WATCHDOG_EN
    assign busErrorOut       = bus_error;
    assign endTransactionOut = bus_error;
`else
    assign busErrorOut       = 1'b0;
    assign endTransactionOut = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: behavioural reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_arbiter_rr;

    localparam int NM = 4;
    localparam int GT = 16;
    localparam int WD = 1023;
`ifdef WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] request = '0;
    logic       beg = 1'b0;
    logic       en = 1'b0;
    logic [3:0] grant;
    logic       bus_error;
    logic       end_out;
    logic [2:0] active_master;

    int n_vec = 0;
    int n_bad = 0;

    bus_arbiter_rr dut (
        .clock              (clock),
        .reset              (reset),
        .request            (request),
        .grant              (grant),
        .beginTransactionIn (beg),
        .endTransactionIn   (en),
        .busErrorOut        (bus_error),
        .endTransactionOut  (end_out),
        .activeMaster       (active_master)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether the owner has begun,
    // how long it has waited/been busy, and whose turn comes next.
    int         m_owner, m_ptr, m_gage, m_bage;
    bit         m_hold, m_busy, m_err;
    logic [3:0] exp_g;

    function automatic void model_reset();
        m_owner = 0; m_ptr = 0; m_gage = 0; m_bage = 0;
        m_hold = 0; m_busy = 0; m_err = 0;
    endfunction

    function automatic void model_step(input logic [3:0] rq, input logic b, input logic e);
        bit fin  = 0;
        bit nerr = 0;
        if (m_hold) begin
            if (!m_busy) begin
                if (b && e) fin = 1;
                else if (b) begin
                    m_busy = 1;
                    m_bage = 0;
                end else begin
                    m_gage++;
                    if (m_gage >= GT || !rq[m_owner]) fin = 1;
                end
            end else begin
                if (e) fin = 1;
                else if (WD_ON) begin
                    if (m_err) fin = 1;
                    else begin
                        m_bage++;
                        if (m_bage == WD) nerr = 1;
                    end
                end
            end
            if (fin) begin
                m_hold = 0;
                m_busy = 0;
                m_ptr  = (m_owner + 1) % NM;
            end
        end else begin
            for (int i = 0; i < NM; i++) begin
                int c = (m_ptr + i) % NM;
                if (rq[c]) begin
                    m_hold  = 1;
                    m_busy  = 0;
                    m_owner = c;
                    m_gage  = 0;
                    break;
                end
            end
        end
        m_err = nerr;
    endfunction

    // Model advance and compare, every clock edge and on async reset.
    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else        model_step(request, beg, en);
        #2;
        exp_g = m_hold ? 4'(1 << m_owner) : 4'b0000;
        check("grant",      32'(grant),             32'(exp_g));
        check("active",     32'(active_master),     32'(m_owner));
        check("bus_error",  32'(bus_error),         32'(m_err));
        check("end_out",    32'(end_out),           32'(m_err));
        check("grant_1hot", 32'($countones(grant) <= 1), 32'd1);
    end

    task automatic step(input logic [3:0] r, input logic b, input logic e);
        @(negedge clock);
        request = r; beg = b; en = e;
        @(posedge clock);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; request = '0; beg = 1'b0; en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    logic [3:0] rmask;
    int         bprob;

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #3;
        check("reset_grant",  32'(grant),         32'd0);
        check("reset_active", 32'(active_master), 32'd0);

        // Single master: grant at 1, begin at 3, end at 7, grant gone at 8.
        step(4'b0100, 1'b0, 1'b0);
        check("single_grant", 32'(grant), 32'h4);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        repeat (3) step(4'b0100, 1'b0, 1'b0);
        check("single_busy", 32'(grant), 32'h4);
        step(4'b0000, 1'b0, 1'b1);
        check("single_release", 32'(grant), 32'h0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);

        // All four requesting, 3-cycle transactions: order 0,1,2,3,0.
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            oh = 4'(1 << order[k]);
            check("rr_order", 32'(grant), 32'(oh));
            step(4'b1111, 1'b1, 1'b0);
            step(4'b1111, 1'b0, 1'b0);
            step(4'b1111, 1'b0, 1'b1);
            check("rr_gap", 32'(grant), 32'h0);
            step(4'b1111, 1'b0, 1'b0);
        end

        // Unused grant times out after 16 cycles; master 3 goes next.
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        check("tmo_grant", 32'(grant), 32'h2);
        repeat (14) step(4'b0010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        check("tmo_last_cycle", 32'(grant), 32'h2);
        step(4'b1010, 1'b0, 1'b0);
        check("tmo_dropped", 32'(grant), 32'h0);
        step(4'b1010, 1'b0, 1'b0);
        check("tmo_next_master", 32'(grant), 32'h8);
        step(4'b0010, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // Reset while master 2 is busy: pointer returns to 0, master 0 wins.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        request = 4'b1001;
        #1;
        check("async_rst_grant",  32'(grant),         32'h0);
        check("async_rst_active", 32'(active_master), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #3;
        check("post_rst_winner", 32'(grant), 32'h1);
        step(4'b1001, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 1'b0, 1'b0);

`ifdef WATCHDOG_EN
        // Watchdog expiry: pulse after 1023 busy cycles, grant drops next cycle.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        repeat (1022) step(4'b0000, 1'b0, 1'b0);
        check("wd_no_early_pulse", 32'(bus_error), 32'd0);
        step(4'b0000, 1'b0, 1'b0);
        check("wd_pulse_err", 32'(bus_error), 32'd1);
        check("wd_pulse_end", 32'(end_out),   32'd1);
        check("wd_pulse_grant", 32'(grant),   32'h1);
        step(4'b0000, 1'b0, 1'b0);
        check("wd_after_grant", 32'(grant),   32'h0);
        check("wd_after_err", 32'(bus_error), 32'd0);

        // End arriving in the expiry cycle wins: no pulse.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        repeat (1022) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        check("wd_race_err",   32'(bus_error), 32'd0);
        check("wd_race_grant", 32'(grant),     32'h0);
`endif

        // Randomized traffic: sticky requests, phases of eager and lazy masters.
        do_reset();
        rmask = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bprob = ((cyc / 500) % 2 == 0) ? 25 : 2;
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 99) < 10) rmask[m] = ~rmask[m];
            end
            step(rmask,
                 ($urandom_range(0, 99) < bprob),
                 ($urandom_range(0, 99) < 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
